// File: rtl/switch_egress_sink.sv
`default_nettype none
// ============================================================================
//  Module      : switch_egress_sink
//  Description : Credit-returning terminating sink for one switch output port.
//                Per-VC FIFOs, round-robin drain with hold-while-stalled.
//  Revision    : 1.0 - initial release
// ============================================================================

package switch_egress_pkg;
    typedef struct packed {
        logic [1:0]  vc;
        logic [31:0] payload;
    } flit_t;
endpackage

module switch_egress_sink
    import switch_egress_pkg::*;
#(
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        data_ready_in,
    input  flit_t                                       flit_in,
    output logic                                        packet_sent,
    output logic [NUM_VCS-1:0]                          credit_granted,
    output flit_t                                       flit_out,
    output logic                                        flit_valid,
    input  logic                                        flit_ready,
    output logic [NUM_VCS*$clog2(BUFFER_SIZE+1)-1:0]    occupancy,
    output logic                                        overflow_err
);

    localparam int c_cnt_w = $clog2(BUFFER_SIZE + 1);
    localparam int c_ptr_w = $clog2(BUFFER_SIZE);
    localparam int c_vc_w  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(BUFFER_SIZE);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(BUFFER_SIZE - 1);

    flit_t               r_mem   [NUM_VCS][BUFFER_SIZE];
    logic [c_ptr_w-1:0]  r_wptr  [NUM_VCS];
    logic [c_ptr_w-1:0]  r_rptr  [NUM_VCS];
    logic [c_cnt_w-1:0]  r_count [NUM_VCS];
    logic [c_vc_w-1:0]   r_rr;
    logic                r_lock;
    logic [c_vc_w-1:0]   r_lock_vc;
    logic                r_packet_sent;
    logic [NUM_VCS-1:0]  r_credit;
    logic                r_overflow;

    logic [c_vc_w-1:0]   w_wvc;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [c_vc_w-1:0]   w_rr_sel;
    logic                w_found;
    logic [c_vc_w-1:0]   w_cand;
    logic [c_vc_w-1:0]   w_sel;
    logic [NUM_VCS-1:0]  w_push_v;
    logic [NUM_VCS-1:0]  w_pop_v;

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    // Out-of-range VC ids fold onto VC 0
    assign w_wvc  = (int'(flit_in.vc) < NUM_VCS) ? c_vc_w'(flit_in.vc) : '0;
    assign w_full = (r_count[w_wvc] == c_full_cnt);
    assign w_push = data_ready_in && !w_full;

    always_comb begin
        w_rr_sel = r_rr;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int i = 1; i <= NUM_VCS; i++) begin
            w_cand = c_vc_w'((int'(r_rr) + i) % NUM_VCS);
            if (!w_found && (r_count[w_cand] != '0)) begin
                w_rr_sel = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    // A stalled head keeps its VC until it is taken
    assign w_sel      = r_lock ? r_lock_vc : w_rr_sel;
    assign flit_valid = (r_count[w_sel] != '0);
    assign w_pop      = flit_valid && flit_ready;
    assign flit_out   = r_mem[w_sel][r_rptr[w_sel]];

    always_comb begin
        w_push_v = '0;
        w_pop_v  = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_push_v[v] = w_push && (w_wvc == c_vc_w'(v));
            w_pop_v[v]  = w_pop  && (w_sel == c_vc_w'(v));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_wptr[v]  <= '0;
                r_rptr[v]  <= '0;
                r_count[v] <= '0;
            end
            r_rr          <= '0;
            r_lock        <= 1'b0;
            r_lock_vc     <= '0;
            r_packet_sent <= 1'b0;
            r_credit      <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_packet_sent <= w_push;
            r_credit      <= w_pop_v;
            if (data_ready_in && w_full)
                r_overflow <= 1'b1;
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_push_v[v])
                    r_wptr[v] <= next_ptr(r_wptr[v]);
                if (w_pop_v[v])
                    r_rptr[v] <= next_ptr(r_rptr[v]);
                if (w_push_v[v] && !w_pop_v[v])
                    r_count[v] <= r_count[v] + 1'b1;
                else if (!w_push_v[v] && w_pop_v[v])
                    r_count[v] <= r_count[v] - 1'b1;
            end
            if (w_pop) begin
                r_rr   <= w_sel;
                r_lock <= 1'b0;
            end else if (flit_valid) begin
                r_lock    <= 1'b1;
                r_lock_vc <= w_sel;
            end
        end
    end

    // Storage needs no reset: counts gate every read
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[w_wvc][r_wptr[w_wvc]] <= flit_in;
    end

    assign packet_sent    = r_packet_sent;
    assign credit_granted = r_credit;
    assign overflow_err   = r_overflow;

    for (genvar g = 0; g < NUM_VCS; g++) begin : g_occ
        assign occupancy[g*c_cnt_w +: c_cnt_w] = r_count[g];
    end

endmodule

`default_nettype wire

// File: tb/tb_switch_egress_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_egress_sink
//  Description : Directed cycle-vector bench for switch_egress_sink.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_switch_egress_sink;
    import switch_egress_pkg::*;

    logic        clk;
    logic        rst;
    logic        data_ready_in;
    flit_t       flit_in;
    logic        packet_sent;
    logic [1:0]  credit_granted;
    flit_t       flit_out;
    logic        flit_valid;
    logic        flit_ready;
    logic [5:0]  occupancy;
    logic        overflow_err;

    switch_egress_sink #(.NUM_VCS(2), .BUFFER_SIZE(4)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .data_ready_in  (data_ready_in),
        .flit_in        (flit_in),
        .packet_sent    (packet_sent),
        .credit_granted (credit_granted),
        .flit_out       (flit_out),
        .flit_valid     (flit_valid),
        .flit_ready     (flit_ready),
        .occupancy      (occupancy),
        .overflow_err   (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        din;
        logic [1:0]  vc;
        logic [31:0] pay;
        logic        rdy;
        logic        chk;
        logic        ps;
        logic [1:0]  cg;
        logic        fv;
        logic [31:0] fo;
        logic [2:0]  o0;
        logic [2:0]  o1;
        logic        ovf;
    } vec_t;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic void add(input logic r, input logic d, input logic [1:0] vc,
                                input logic [31:0] pay, input logic rdy,
                                input logic ps, input logic [1:0] cg, input logic fv,
                                input logic [31:0] fo, input logic [2:0] o0,
                                input logic [2:0] o1, input logic ovf);
        vec_t t;
        t.rst = r;  t.din = d;  t.vc = vc; t.pay = pay; t.rdy = rdy; t.chk = 1'b1;
        t.ps  = ps; t.cg  = cg; t.fv = fv; t.fo  = fo;  t.o0  = o0;  t.o1  = o1;
        t.ovf = ovf;
        vq.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic d, input logic [1:0] vc,
                         input logic [31:0] pay, input logic rdy);
        rst           = r;
        data_ready_in = d;
        flit_in.vc    = vc;
        flit_in.payload = pay;
        flit_ready    = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got [$];
        int          cyc;

        drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b0);

        // reset (state unknown before it, so no check)
        add(1,0,0,0,0,           0,0,0,0,0,0,0); vq[0].chk = 1'b0;
        // single flit through VC0
        add(0,1,0,32'hA5A50001,1, 0,0,0,0,0,0,0);
        add(0,0,0,0,1,           1,0,1,32'hA5A50001,1,0,0);
        add(0,0,0,0,1,           0,1,0,0,0,0,0);
        add(0,0,0,0,0,           0,0,0,0,0,0,0);
        // fill VC1, 5th write overflows, then drain
        add(0,1,1,32'hB0,0,      0,0,0,0,0,0,0);
        add(0,1,1,32'hB1,0,      1,0,1,32'hB0,0,1,0);
        add(0,1,1,32'hB2,0,      1,0,1,32'hB0,0,2,0);
        add(0,1,1,32'hB3,0,      1,0,1,32'hB0,0,3,0);
        add(0,1,1,32'hB4,0,      1,0,1,32'hB0,0,4,0);
        add(0,0,0,0,1,           0,0,1,32'hB0,0,4,1);
        add(0,0,0,0,1,           0,2,1,32'hB1,0,3,1);
        add(0,0,0,0,1,           0,2,1,32'hB2,0,2,1);
        add(0,0,0,0,1,           0,2,1,32'hB3,0,1,1);
        add(0,0,0,0,1,           0,2,0,0,0,0,1);
        add(0,0,0,0,0,           0,0,0,0,0,0,1);
        // reset, then 3+3 flits and round-robin drain
        add(1,0,0,0,0,           0,0,0,0,0,0,1);
        add(0,1,1,32'hC10,0,     0,0,0,0,0,0,0);
        add(0,1,0,32'hC00,0,     1,0,1,32'hC10,0,1,0);
        add(0,1,1,32'hC11,0,     1,0,1,32'hC10,1,1,0);
        add(0,1,0,32'hC01,0,     1,0,1,32'hC10,1,2,0);
        add(0,1,1,32'hC12,0,     1,0,1,32'hC10,2,2,0);
        add(0,1,0,32'hC02,0,     1,0,1,32'hC10,2,3,0);
        add(0,0,0,0,1,           1,0,1,32'hC10,3,3,0);
        add(0,0,0,0,1,           0,2,1,32'hC00,3,2,0);
        add(0,0,0,0,1,           0,1,1,32'hC11,2,2,0);
        add(0,0,0,0,1,           0,2,1,32'hC01,2,1,0);
        add(0,0,0,0,1,           0,1,1,32'hC12,1,1,0);
        add(0,0,0,0,1,           0,2,1,32'hC02,1,0,0);
        add(0,0,0,0,1,           0,1,0,0,0,0,0);
        add(0,0,0,0,0,           0,0,0,0,0,0,0);
        // stalled VC0 head stays selected while VC1 fills
        add(0,1,0,32'hD00,0,     0,0,0,0,0,0,0);
        add(0,1,1,32'hD10,0,     1,0,1,32'hD00,1,0,0);
        add(0,1,1,32'hD11,0,     1,0,1,32'hD00,1,1,0);
        add(0,1,1,32'hD12,0,     1,0,1,32'hD00,1,2,0);
        add(0,0,0,0,0,           1,0,1,32'hD00,1,3,0);
        add(0,0,0,0,0,           0,0,1,32'hD00,1,3,0);
        add(0,0,0,0,1,           0,0,1,32'hD00,1,3,0);
        add(0,0,0,0,1,           0,1,1,32'hD10,0,3,0);
        add(0,0,0,0,0,           0,2,1,32'hD11,0,2,0);
        // same-cycle write+pop on VC0, then reset with 3 flits buffered
        add(1,0,0,0,0,           0,0,1,32'hD11,0,2,0);
        add(0,1,0,32'hE00,0,     0,0,0,0,0,0,0);
        add(0,1,0,32'hE01,0,     1,0,1,32'hE00,1,0,0);
        add(0,1,0,32'hE02,1,     1,0,1,32'hE00,2,0,0);
        add(0,0,0,0,0,           1,1,1,32'hE01,2,0,0);
        add(0,1,1,32'hF10,0,     0,0,1,32'hE01,2,0,0);
        add(1,0,0,0,0,           1,0,1,32'hE01,2,1,0);
        add(0,0,0,0,1,           0,0,0,0,0,0,0);
        // vc id 2 folds onto VC0
        add(0,1,2,32'h600,0,     0,0,0,0,0,0,0);
        add(0,0,0,0,0,           1,0,1,32'h600,1,0,0);
        add(0,0,0,0,1,           0,0,1,32'h600,1,0,0);
        add(0,0,0,0,0,           0,1,0,0,0,0,0);

        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k].rst, vq[k].din, vq[k].vc, vq[k].pay, vq[k].rdy);
            #1;
            if (vq[k].chk) begin
                chk($sformatf("v%0d_packet_sent", k), 32'(packet_sent), 32'(vq[k].ps));
                chk($sformatf("v%0d_credit", k), 32'(credit_granted), 32'(vq[k].cg));
                chk($sformatf("v%0d_valid", k), 32'(flit_valid), 32'(vq[k].fv));
                if (vq[k].fv)
                    chk($sformatf("v%0d_payload", k), flit_out.payload, vq[k].fo);
                chk($sformatf("v%0d_occ", k), 32'(occupancy), 32'({vq[k].o1, vq[k].o0}));
                chk($sformatf("v%0d_overflow", k), 32'(overflow_err), 32'(vq[k].ovf));
            end
        end

        // Full VC with a same-cycle pop still drops the incoming write
        @(negedge clk); drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(1'b0, 1'b1, 2'd0, 32'h100 + 32'(i), 1'b0);
        end
        @(negedge clk); drive(1'b0, 1'b1, 2'd0, 32'h104, 1'b1);
        #1;
        chk("full_occ", 32'(occupancy[2:0]), 32'd4);
        @(negedge clk); drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
        #1;
        chk("full_drop_ps", 32'(packet_sent), 32'd0);
        chk("full_drop_ovf", 32'(overflow_err), 32'd1);
        chk("full_drop_occ", 32'(occupancy[2:0]), 32'd3);
        chk("full_drop_cg", 32'(credit_granted), 32'd1);

        flit_ready = 1'b1;
        cyc = 0;
        while (cyc < 10) begin
            #1;
            if (!flit_valid) break;
            got.push_back(flit_out.payload);
            @(negedge clk);
            cyc++;
        end
        chk("drain_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("drain_order%0d", i),
                (i < got.size()) ? got[i] : 32'hFFFFFFFF, 32'h101 + 32'(i));
        chk("drain_occ", 32'(occupancy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
